// File: rtl/pipemem_pkg.sv
// pipemem_pkg: shared state encodings and defaults for the pipeline memory arbiter
package pipemem_pkg;
  typedef enum logic [1:0] {IDLE, IF_ACC, DM_ACC, RESP} state_t;
  localparam int TMO_DEFAULT = 15;
endpackage

// File: rtl/pipemem_arb.sv
// pipemem_arb: arbitrates fetch and data requests onto one single-port memory
module pipemem_arb
  import pipemem_pkg::*;
#(
  parameter int TMO = TMO_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        err
);
  state_t      state, nxt;
  logic [1:0]  skip;
  logic [7:0]  wcnt;
  logic        grant_d, lat_we;
  logic [31:0] lat_addr, lat_wdata;
  logic        grant_if, acc, timeout, done;
  // fetch wins a tie only after losing twice in a row
  assign grant_if  = if_req && (!dm_req || skip == 2'd2);
  assign acc       = state == IF_ACC || state == DM_ACC;
  assign timeout   = acc && !mem_ack && wcnt == 8'(TMO - 1);
  assign done      = acc && (mem_ack || timeout);
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  always_ff @(posedge clock)
    if (reset) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state == IDLE ? (grant_if ? IF_ACC : dm_req ? DM_ACC : IDLE) :
          state == RESP ? IDLE : done ? RESP : state;
  end
  always_comb begin
    mem_en   = acc;
    mem_we   = state == DM_ACC && lat_we;
    if_ready = state == RESP && !grant_d;
    dm_ready = state == RESP && grant_d;
  end
  always_ff @(posedge clock)
    if (reset) begin
      skip      <= '0;
      wcnt      <= '0;
      err       <= 1'b0;
      grant_d   <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      if_rdata  <= '0;
      dm_rdata  <= '0;
    end else begin
      wcnt <= acc && !mem_ack ? wcnt + 8'd1 : 8'd0;
      if (state == IDLE && grant_if) begin
        grant_d  <= 1'b0;
        lat_we   <= 1'b0;
        lat_addr <= if_addr;
        skip     <= '0;
      end else if (state == IDLE && dm_req) begin
        grant_d   <= 1'b1;
        lat_we    <= dm_we;
        lat_addr  <= dm_addr;
        lat_wdata <= dm_wdata;
        if (if_req && skip != 2'd2) skip <= skip + 2'd1;
      end
      // an aborted access returns zero and latches the error flag
      if (done) begin
        if (state == IF_ACC) if_rdata <= mem_ack ? mem_rdata : '0;
        else if (!lat_we) dm_rdata <= mem_ack ? mem_rdata : '0;
        if (!mem_ack) err <= 1'b1;
      end
    end
endmodule

// File: tb/tb_pipemem_arb.sv
// tb_pipemem_arb: directed self-checking bench for pipemem_arb
module tb_pipemem_arb;
  logic        clock = 1'b0;
  logic        reset;
  logic        if_req, dm_req, dm_we, mem_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, mem_rdata;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic        if_ready, dm_ready, mem_en, mem_we, err;
  int checks = 0;
  int fails = 0;

  always #5 clock = ~clock;

  pipemem_arb dut (
    .clock(clock), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .err(err)
  );

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; if_req = 0; dm_req = 0; dm_we = 0; mem_ack = 0;
    if_addr = 0; dm_addr = 0; dm_wdata = 0; mem_rdata = 0;
    tick; tick;
    reset = 1'b0;
    checks++;
    if ({mem_en, mem_we, if_ready, dm_ready, err} !== 5'b0) begin
      fails++; $display("FAIL reset_ctrl got %b want 00000", {mem_en, mem_we, if_ready, dm_ready, err});
    end
    checks++;
    if ({if_rdata, dm_rdata} !== 64'h0) begin
      fails++; $display("FAIL reset_rdata got %h want 0", {if_rdata, dm_rdata});
    end
  endtask

  task automatic test_load;
    dm_req = 1; dm_we = 0; dm_addr = 32'h40;
    tick;
    dm_req = 0; mem_ack = 1; mem_rdata = 32'h12345678;
    checks++;
    if ({mem_en, mem_we} !== 2'b10 || mem_addr !== 32'h40) begin
      fails++; $display("FAIL load_acc en/we %b addr %h want 10 00000040", {mem_en, mem_we}, mem_addr);
    end
    tick;
    mem_ack = 0;
    checks++;
    if ({dm_ready, if_ready, mem_en} !== 3'b100) begin
      fails++; $display("FAIL load_ready got %b want 100", {dm_ready, if_ready, mem_en});
    end
    checks++;
    if (dm_rdata !== 32'h12345678) begin
      fails++; $display("FAIL load_data got %h want 12345678", dm_rdata);
    end
    tick;
    checks++;
    if (dm_ready !== 1'b0 || dm_rdata !== 32'h12345678) begin
      fails++; $display("FAIL load_hold ready %b data %h want 0 12345678", dm_ready, dm_rdata);
    end
  endtask

  task automatic test_back_to_back;
    logic exp_i;
    logic [5:0] order;
    order = 6'b001001;
    reset = 1; tick; reset = 0;
    if_req = 1; dm_req = 1; dm_we = 0; if_addr = 32'h100; dm_addr = 32'h200; mem_ack = 1;
    for (int i = 0; i < 6; i++) begin
      exp_i = order[5 - i];
      mem_rdata = 32'hA0000000 + i;
      checks++;
      if (mem_en !== 1'b0) begin
        fails++; $display("FAIL b2b_idle[%0d] mem_en %b want 0", i, mem_en);
      end
      tick;
      checks++;
      if (mem_en !== 1'b1 || mem_addr !== (exp_i ? 32'h100 : 32'h200)) begin
        fails++; $display("FAIL b2b_grant[%0d] en %b addr %h want 1 %h", i, mem_en, mem_addr, exp_i ? 32'h100 : 32'h200);
      end
      tick;
      if (i == 5) begin if_req = 0; dm_req = 0; end
      checks++;
      if ({if_ready, dm_ready} !== {exp_i, !exp_i}) begin
        fails++; $display("FAIL b2b_ready[%0d] got %b want %b", i, {if_ready, dm_ready}, {exp_i, !exp_i});
      end
      tick;
    end
    checks++;
    if (if_rdata !== 32'hA0000005 || dm_rdata !== 32'hA0000004) begin
      fails++; $display("FAIL b2b_data if %h dm %h want a0000005 a0000004", if_rdata, dm_rdata);
    end
  endtask

  task automatic test_store;
    mem_ack = 0; dm_req = 1; dm_we = 1; dm_addr = 32'h80; dm_wdata = 32'hCAFEF00D;
    tick;
    dm_req = 0; dm_we = 0; mem_ack = 1; mem_rdata = 32'hDEADBEEF;
    checks++;
    if ({mem_en, mem_we} !== 2'b11 || mem_addr !== 32'h80 || mem_wdata !== 32'hCAFEF00D) begin
      fails++; $display("FAIL store_acc en/we %b addr %h wdata %h", {mem_en, mem_we}, mem_addr, mem_wdata);
    end
    tick;
    mem_ack = 0;
    checks++;
    if (dm_ready !== 1'b1 || dm_rdata !== 32'hA0000004 || mem_we !== 1'b0) begin
      fails++; $display("FAIL store_resp ready %b data %h we %b want 1 a0000004 0", dm_ready, dm_rdata, mem_we);
    end
    tick;
  endtask

  task automatic test_timeout;
    int cnt;
    logic seen;
    cnt = 0; seen = 0;
    if_req = 1; if_addr = 32'h300; mem_ack = 0;
    tick;
    if_req = 0;
    checks++;
    if (err !== 1'b0) begin
      fails++; $display("FAIL tmo_err_early got %b want 0", err);
    end
    for (int k = 0; k < 40; k++) begin
      if (if_ready) begin seen = 1; break; end
      if (mem_en) cnt++;
      tick;
    end
    checks++;
    if (!seen || cnt != 15) begin
      fails++; $display("FAIL tmo_cycles ready_seen %b acc_cycles %0d want 1 15", seen, cnt);
    end
    checks++;
    if (if_rdata !== 32'h0 || err !== 1'b1 || mem_en !== 1'b0) begin
      fails++; $display("FAIL tmo_result rdata %h err %b en %b want 0 1 0", if_rdata, err, mem_en);
    end
    tick; tick; tick;
    checks++;
    if (err !== 1'b1 || if_ready !== 1'b0) begin
      fails++; $display("FAIL tmo_sticky err %b ready %b want 1 0", err, if_ready);
    end
  endtask

  task automatic test_reset_mid;
    dm_req = 1; dm_we = 0; dm_addr = 32'h40; mem_ack = 0;
    tick;
    dm_req = 0;
    checks++;
    if (mem_en !== 1'b1) begin
      fails++; $display("FAIL mid_acc mem_en %b want 1", mem_en);
    end
    reset = 1;
    tick;
    reset = 0; mem_ack = 1; mem_rdata = 32'h55;
    checks++;
    if ({mem_en, mem_we, dm_ready, if_ready, err} !== 5'b0 || {if_rdata, dm_rdata} !== 64'h0) begin
      fails++; $display("FAIL mid_reset ctrl %b data %h want 00000 0", {mem_en, mem_we, dm_ready, if_ready, err}, {if_rdata, dm_rdata});
    end
    for (int k = 0; k < 3; k++) begin
      tick;
      checks++;
      if ({mem_en, dm_ready, if_ready} !== 3'b0 || dm_rdata !== 32'h0) begin
        fails++; $display("FAIL mid_late_ack[%0d] ctrl %b data %h want 000 0", k, {mem_en, dm_ready, if_ready}, dm_rdata);
      end
    end
    mem_ack = 0;
  endtask

  initial begin
    test_reset;
    test_load;
    test_back_to_back;
    test_store;
    test_timeout;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule

// File: doc/pipemem_arb.md
PIPEMEM_ARB -- requirements
Module: pipemem_arb

Interface
REQ-001 SHALL have parameter TMO, default 15, meaning the max cycles waited for mem_ack before abort (1..255).
REQ-002 SHALL have ports: clock  in  1  rising-edge clock (one clock, no others).
REQ-003 SHALL have: reset  in  1  synchronous, active-high reset.
REQ-004 SHALL have: if_req in 1 fetch request; if_addr in 32 fetch address.
REQ-005 SHALL have: if_rdata out 32 fetched word; if_ready out 1 fetch-complete pulse.
REQ-006 SHALL have: dm_req in 1 MEM-stage request; dm_we in 1 store(1)/load(0); dm_addr in 32; dm_wdata in 32.
REQ-007 SHALL have: dm_rdata out 32 load data; dm_ready out 1 data-complete pulse.
REQ-008 SHALL have: mem_en out 1; mem_we out 1; mem_addr out 32; mem_wdata out 32; mem_rdata in 32; mem_ack in 1 (single-port unified memory).
REQ-009 SHALL have: err out 1 sticky timeout flag.

Function
REQ-010 SHALL implement FSM states IDLE, IF_ACC, DM_ACC, RESP.
REQ-011 In IDLE with only dm_req=1: latch dm_we/addr/wdata, grant data, next state DM_ACC.
REQ-012 In IDLE with only if_req=1: latch if_addr, grant fetch, next state IF_ACC.
REQ-013 In IDLE with both requests: data wins, unless skip counter = 2, then fetch wins.
REQ-014 Skip counter (2-bit): increments when fetch loses with if_req=1, clears on any fetch grant, saturates at 2.
REQ-015 In IF_ACC/DM_ACC: mem_en=1, mem_addr/mem_wdata/mem_we driven from latched values, stable for the whole access; mem_we=0 in IF_ACC.
REQ-016 Outside the ACC states: mem_en=0, mem_we=0.
REQ-017 On mem_ack=1 in an ACC state: capture mem_rdata into if_rdata (fetch) or dm_rdata (data, loads only), next state RESP.
REQ-018 In RESP: exactly one of if_ready/dm_ready =1 for that single cycle, matching the grant; both requests ignored; next state IDLE.
REQ-019 if_rdata/dm_rdata SHALL hold their value until the next completion of the same kind; a store leaves dm_rdata unchanged.
REQ-020 Minimum latency: req in IDLE at cycle 0, ack at cycle 1 -> ready at cycle 2; back-to-back grant earliest at cycle 3.
REQ-021 Wait counter clears on entry to an ACC state and increments each ACC cycle with mem_ack=0; at count = TMO: abort, set err=1, load 0x00000000 into the granted rdata, go to RESP (ready still pulses).
REQ-022 mem_ack outside ACC states SHALL be ignored.
REQ-023 if_ready and dm_ready SHALL never be 1 in the same cycle.

Reset
REQ-024 reset=1 at a rising edge SHALL force IDLE, clear skip/wait counters, err=0, if_ready=dm_ready=0, if_rdata=dm_rdata=0; mem_en=mem_we=0 from that edge.
REQ-025 Reset mid-access SHALL abort without a ready pulse; a late mem_ack after reset is ignored.

Structure
REQ-026 State encodings and TMO default SHALL live in shared package pipemem_pkg.
REQ-027 No sub-module; the FSM, skip counter and wait counter SHALL be in one module.

Verification
REQ-028 dm_req=1, dm_we=0, dm_addr=0x40 in IDLE, mem_ack at next cycle with mem_rdata=0x12345678 -> mem_addr=0x40, dm_ready=1 two cycles after request, dm_rdata=0x12345678.
REQ-029 if_req and dm_req both held high, ack always 1 -> grant order D,D,I,D,D,I (skip-counter fairness); ready pulses never overlap.
REQ-030 store dm_we=1, dm_wdata=0xCAFEF00D, addr 0x80 -> mem_we=1, mem_wdata=0xCAFEF00D for the ACC cycle; dm_rdata unchanged.
REQ-031 if_req with mem_ack held 0, TMO=15 -> after 15 ACC cycles if_ready=1, if_rdata=0, err=1 and stays 1 until reset.
REQ-032 reset asserted during DM_ACC, then mem_ack=1 -> no dm_ready, mem_en=0, state IDLE, outputs at reset values.
